// File: rtl/stopwatch_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stopwatch_controller
// Turns two debounced push-buttons (start/stop, lap/clear) into control for the
// stopwatch counter. It drives the counter enable and a one-cycle clear pulse,
// captures a split (lap) time, and selects live or frozen time for the display.
//
// Ports
//   clk        in   system clock (also feeds the counter's clock divider)
//   reset      in   asynchronous active-high reset
//   btn_ss     in   start/stop button, debounced, asynchronous to clk
//   btn_lr     in   lap/clear button, debounced, asynchronous to clk
//   ms_in      in   live milliseconds 0..999
//   sec_in     in   live seconds 0..59
//   min_in     in   live minutes 0..59
//   sw_enable  out  counter enable (high in RUN and LAP)
//   sw_clear   out  one-cycle registered clear pulse to the counter
//   disp_ms    out  displayed milliseconds
//   disp_sec   out  displayed seconds
//   disp_min   out  displayed minutes
//   state_out  out  IDLE=00, RUN=01, LAP=10, PAUSE=11
//   lap_count  out  number of lap captures, saturating at LAP_SAT
//                   (present only when STOPWATCH_LAP_COUNT_EN is defined)
//
// Optional feature macro: STOPWATCH_LAP_COUNT_EN
//   Adds parameter LAP_SAT (1..15, default 15) and the lap_count output.
// -----------------------------------------------------------------------------
module stopwatch_controller
`ifdef STOPWATCH_LAP_COUNT_EN
#(
   parameter int unsigned LAP_SAT = 15
)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lr,
   input  logic [9:0] ms_in,
   input  logic [5:0] sec_in,
   input  logic [5:0] min_in,
   output logic       sw_enable,
   output logic       sw_clear,
   output logic [9:0] disp_ms,
   output logic [5:0] disp_sec,
   output logic [5:0] disp_min,
   output logic [1:0] state_out
`ifdef STOPWATCH_LAP_COUNT_EN
   ,
   output logic [3:0] lap_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_LAP   = 2'b10,
      S_PAUSE = 2'b11
   } state_t;

   state_t     r_state;
   logic       r_sw_enable;
   logic       r_sw_clear;
   logic [9:0] r_lap_ms;
   logic [5:0] r_lap_sec;
   logic [5:0] r_lap_min;

   // Per button: bit0 = s1, bit1 = s2 (synchronized), bit2 = s3 (previous).
   logic [2:0] r_ss_sync;
   logic [2:0] r_lr_sync;

   logic       w_ss_press;
   logic       w_lr_press;

`ifdef STOPWATCH_LAP_COUNT_EN
   localparam logic [3:0] LC_SAT = 4'(LAP_SAT);
   logic [3:0] r_lap_count;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ss_sync <= 3'b000;
         r_lr_sync <= 3'b000;
      end else begin
         r_ss_sync <= {r_ss_sync[1:0], btn_ss};
         r_lr_sync <= {r_lr_sync[1:0], btn_lr};
      end
   end

   // Rising edge of the synchronized level; start/stop has priority, so a
   // simultaneous lap/clear press is dropped.
   assign w_ss_press = r_ss_sync[1] & ~r_ss_sync[2];
   assign w_lr_press = r_lr_sync[1] & ~r_lr_sync[2] & ~w_ss_press;

   // Control FSM. sw_enable is registered together with the next state so the
   // counter enable comes straight off a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sw_enable <= 1'b0;
         r_sw_clear  <= 1'b0;
         r_lap_ms    <= '0;
         r_lap_sec   <= '0;
         r_lap_min   <= '0;
`ifdef STOPWATCH_LAP_COUNT_EN
         r_lap_count <= '0;
`endif
      end else begin
         r_sw_clear <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_ss_press) begin
                  r_state     <= S_RUN;
                  r_sw_enable <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_ss_press) begin
                  r_state     <= S_PAUSE;
                  r_sw_enable <= 1'b0;
               end else if (w_lr_press) begin
                  r_state   <= S_LAP;
                  r_lap_ms  <= ms_in;
                  r_lap_sec <= sec_in;
                  r_lap_min <= min_in;
`ifdef STOPWATCH_LAP_COUNT_EN
                  if (r_lap_count != LC_SAT)
                     r_lap_count <= r_lap_count + 4'd1;
`endif
               end
            end
            S_LAP: begin
               // Counter keeps running here; only the display is frozen.
               if (w_ss_press) begin
                  r_state     <= S_PAUSE;
                  r_sw_enable <= 1'b0;
               end else if (w_lr_press) begin
                  r_state <= S_RUN;
               end
            end
            S_PAUSE: begin
               if (w_ss_press) begin
                  r_state     <= S_RUN;
                  r_sw_enable <= 1'b1;
               end else if (w_lr_press) begin
                  r_state    <= S_IDLE;
                  r_sw_clear <= 1'b1;
`ifdef STOPWATCH_LAP_COUNT_EN
                  r_lap_count <= '0;
`endif
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_sw_enable <= 1'b0;
            end
         endcase
      end
   end

   assign sw_enable = r_sw_enable;
   assign sw_clear  = r_sw_clear;
   assign state_out = r_state;

   assign disp_ms  = (r_state == S_LAP) ? r_lap_ms  : ms_in;
   assign disp_sec = (r_state == S_LAP) ? r_lap_sec : sec_in;
   assign disp_min = (r_state == S_LAP) ? r_lap_min : min_in;

`ifdef STOPWATCH_LAP_COUNT_EN
   assign lap_count = r_lap_count;
`endif

endmodule
